// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit common-anode seven-segment scan controller.
// Scans a packed hex value across NUM_DIGITS digits with per-digit enable
// and blink, and overlays a timed PASS/FAIL flash when the checker reports
// a result. Refresh and blink timing are derived from the system clock.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLINK_DIV     = 50000000,
    parameter int RESULT_BLINKS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    result_valid,
    input  logic                    result_pass,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    busy
);

    // Counter widths; a divide-by-1 or single digit still needs a 1-bit register.
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int CW = $clog2(2 * RESULT_BLINKS + 1);

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] RESULT_LOAD  = CW'(2 * RESULT_BLINKS);

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;

    typedef enum logic [0:0] {
        ST_SHOW   = 1'b0,
        ST_RESULT = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [RW-1:0]   refresh_cnt_r, refresh_cnt_s;
    logic [BW-1:0]   blink_cnt_r, blink_cnt_s;
    logic            blink_phase_r, blink_phase_s;
    logic [CW-1:0]   result_cnt_r, result_cnt_s;
    logic            pass_r, pass_s;
    logic            busy_r, busy_s;
    logic            refresh_term_s;
    logic            blink_term_s;

    logic [NUM_DIGITS-1:0] anode_r, anode_s;
    logic [6:0]            seg_r, seg_s;
    logic [3:0]            nibble_s;
    logic                  digit_on_s;
    logic                  digit_blink_s;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Next-state logic: free-running refresh/blink timing plus SHOW/RESULT mode control.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        refresh_cnt_s = refresh_cnt_r;
        blink_cnt_s   = blink_cnt_r;
        blink_phase_s = blink_phase_r;
        result_cnt_s  = result_cnt_r;
        pass_s        = pass_r;
        busy_s        = busy_r;

        refresh_term_s = (refresh_cnt_r == REFRESH_LAST);
        blink_term_s   = (blink_cnt_r == BLINK_LAST);

        // Digit scanning never stops, whatever the mode.
        if (refresh_term_s) begin
            refresh_cnt_s = {RW{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_s = {IW{1'b0}};
            end else begin
                idx_s = idx_r + IW'(1);
            end
        end else begin
            refresh_cnt_s = refresh_cnt_r + RW'(1);
        end

        if (blink_term_s) begin
            blink_cnt_s   = {BW{1'b0}};
            blink_phase_s = ~blink_phase_r;
        end else begin
            blink_cnt_s   = blink_cnt_r + BW'(1);
        end

        case (state_r)
            ST_SHOW: begin
                if (result_valid) begin
                    // Restart blink timing so the flash begins with a full "on" half-period.
                    state_s       = ST_RESULT;
                    pass_s        = result_pass;
                    blink_cnt_s   = {BW{1'b0}};
                    blink_phase_s = 1'b0;
                    result_cnt_s  = RESULT_LOAD;
                    busy_s        = 1'b1;
                end else begin
                    busy_s        = 1'b0;
                end
            end
            ST_RESULT: begin
                // Further result pulses are deliberately ignored here.
                if (blink_term_s) begin
                    result_cnt_s = result_cnt_r - CW'(1);
                    if (result_cnt_r == CW'(1)) begin
                        state_s = ST_SHOW;
                        busy_s  = 1'b0;
                    end else begin
                        busy_s  = 1'b1;
                    end
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_SHOW;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Output decode for the digit currently selected by the scan index.
    always_comb begin
        anode_s       = {NUM_DIGITS{1'b1}};
        seg_s         = GLYPH_BLANK;
        nibble_s      = value[4*idx_r +: 4];
        digit_on_s    = digit_en[idx_r];
        digit_blink_s = blink_mask[idx_r];

        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_s[i] = (idx_r != IW'(i));
        end

        case (state_r)
            ST_SHOW: begin
                if (!digit_on_s || (digit_blink_s && blink_phase_r)) begin
                    seg_s = GLYPH_BLANK;
                end else begin
                    seg_s = hex_glyph(nibble_s);
                end
            end
            ST_RESULT: begin
                if (blink_phase_r) begin
                    seg_s = GLYPH_BLANK;
                end else begin
                    seg_s = pass_r ? GLYPH_P : GLYPH_F;
                end
            end
            default: begin
                seg_s = GLYPH_BLANK;
            end
        endcase
    end

    // Mode, timing counters and latched result kind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_SHOW;
            idx_r         <= {IW{1'b0}};
            refresh_cnt_r <= {RW{1'b0}};
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= 1'b0;
            result_cnt_r  <= {CW{1'b0}};
            pass_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            refresh_cnt_r <= refresh_cnt_s;
            blink_cnt_r   <= blink_cnt_s;
            blink_phase_r <= blink_phase_s;
            result_cnt_r  <= result_cnt_s;
            pass_r        <= pass_s;
            busy_r        <= busy_s;
        end
    end

    // Registered pin drivers; reset turns every digit and segment off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_r <= {NUM_DIGITS{1'b1}};
            seg_r   <= GLYPH_BLANK;
        end else begin
            anode_r <= anode_s;
            seg_r   <= seg_s;
        end
    end

    assign anode = anode_r;
    assign seg   = seg_r;
    assign busy  = busy_r;

endmodule
